uart_rx_ok: RTL and testbench

UART_RX_OK -- requirements
Module: uart_rx_ok

---
 rtl/uart_rx_ok_pkg.sv | 20 ++
 rtl/uart_rx_ok_ok_seq_detect.sv | 71 +++++++
 rtl/uart_rx_ok.sv | 144 ++++++++++++++
 tb/tb_uart_rx_ok.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_ok_pkg.sv
// rtl/uart_rx_ok_pkg.sv - shared constants for the OK-response UART receiver
package uart_rx_ok_pkg;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_START     = 3'd1;
   localparam logic [2:0] ST_DATA      = 3'd2;
   localparam logic [2:0] ST_STOP      = 3'd3;
   localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

   localparam logic [7:0] OK_BYTE0 = 8'h4F;
   localparam logic [7:0] OK_BYTE1 = 8'h4B;
   localparam logic [7:0] OK_BYTE2 = 8'h0D;
   localparam logic [7:0] OK_BYTE3 = 8'h0A;

   // Clock cycles per bit on the line.
   function automatic int unsigned div_num(input int unsigned clk_hz, input int unsigned baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/uart_rx_ok_ok_seq_detect.sv
// rtl/uart_rx_ok_ok_seq_detect.sv - tracks received bytes for the "OK\r\n" response
module ok_seq_detect
   import uart_rx_ok_pkg::*;
(
   input  logic       iCLK,
   input  logic       RST_n,
   input  logic [7:0] byte_in,
   input  logic       strobe,
   input  logic       enable,
   input  logic       clear_req,
   output logic       found
);

   logic [1:0] idx_q, idx_d;
   logic       found_q, found_d;
   logic [7:0] expected;
   logic       set_found;

   always_comb begin
      case (idx_q)
         2'd0:    expected = OK_BYTE0;
         2'd1:    expected = OK_BYTE1;
         2'd2:    expected = OK_BYTE2;
         default: expected = OK_BYTE3;
      endcase
   end

   // A mismatching 'O' can itself begin a new response, so restart at index 1.
   always_comb begin
      idx_d     = idx_q;
      set_found = 1'b0;
      if (!enable) begin
         idx_d = 2'd0;
      end else if (strobe) begin
         if (byte_in == expected) begin
            if (idx_q == 2'd3) begin
               set_found = 1'b1;
               idx_d     = 2'd0;
            end else begin
               idx_d = idx_q + 2'd1;
            end
         end else if (byte_in == OK_BYTE0) begin
            idx_d = 2'd1;
         end else begin
            idx_d = 2'd0;
         end
      end
   end

   always_comb begin
      found_d = found_q;
      if (set_found) begin
         found_d = 1'b1;
      end else if (clear_req) begin
         found_d = 1'b0;
      end
   end

   always_ff @(posedge iCLK or negedge RST_n) begin
      if (!RST_n) begin
         idx_q   <= 2'd0;
         found_q <= 1'b0;
      end else begin
         idx_q   <= idx_d;
         found_q <= found_d;
      end
   end

   assign found = found_q;

endmodule

// File: rtl/uart_rx_ok.sv
// rtl/uart_rx_ok.sv - 8N1 UART receiver that flags the modem's "OK\r\n" reply
module uart_rx_ok
   import uart_rx_ok_pkg::*;
#(
   parameter int CLK       = 50_000_000,
   parameter int BAUD_RATE = 115200
)
(
   input  logic       iCLK,
   input  logic       RST_n,
   input  logic       rx,
   input  logic       receive_ok_en,
   input  logic       SEND_END_cmd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       receiver_OK_ser
);

   localparam int unsigned DIV_NUM = div_num(CLK, BAUD_RATE);
   localparam int          CW      = $clog2(DIV_NUM);
   localparam logic [CW-1:0] CNT_MAX    = CW'(DIV_NUM - 1);
   localparam logic [CW-1:0] CNT_SAMPLE = CW'(DIV_NUM / 2);

   logic          rx_meta_q, rx_sync_q, rx_prev_q;
   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    rx_data_q, rx_data_d;
   logic          rx_valid_q, rx_valid_d;
   logic          frame_err_q, frame_err_d;
   logic          ok_en_prev_q;
   logic          falling;
   logic          sample;
   logic          clear_req;

   assign falling = rx_prev_q & ~rx_sync_q;
   assign sample  = (cnt_q == CNT_SAMPLE);

   always_comb begin
      state_d     = state_q;
      cnt_d       = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      frame_err_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (falling) begin
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (sample) begin
               if (!rx_sync_q) begin
                  state_d   = ST_DATA;
                  bit_idx_d = 3'd0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_DATA: begin
            if (sample) begin
               shift_d   = {rx_sync_q, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
                  state_d = ST_STOP;
               end
            end
         end
         ST_STOP: begin
            if (sample) begin
               if (rx_sync_q) begin
                  rx_data_d  = shift_q;
                  rx_valid_d = 1'b1;
                  state_d    = ST_IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = ST_WAIT_HIGH;
               end
            end
         end
         ST_WAIT_HIGH: begin
            // A broken frame leaves the line low; re-arm only once it idles high.
            cnt_d = '0;
            if (rx_sync_q) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge iCLK or negedge RST_n) begin
      if (!RST_n) begin
         rx_meta_q    <= 1'b1;
         rx_sync_q    <= 1'b1;
         rx_prev_q    <= 1'b1;
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         bit_idx_q    <= 3'd0;
         shift_q      <= 8'h00;
         rx_data_q    <= 8'h00;
         rx_valid_q   <= 1'b0;
         frame_err_q  <= 1'b0;
         ok_en_prev_q <= 1'b0;
      end else begin
         rx_meta_q    <= rx;
         rx_sync_q    <= rx_meta_q;
         rx_prev_q    <= rx_sync_q;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bit_idx_q    <= bit_idx_d;
         shift_q      <= shift_d;
         rx_data_q    <= rx_data_d;
         rx_valid_q   <= rx_valid_d;
         frame_err_q  <= frame_err_d;
         ok_en_prev_q <= receive_ok_en;
      end
   end

   assign clear_req = ok_en_prev_q & ~receive_ok_en;

   ok_seq_detect u_ok_seq_detect (
      .iCLK      (iCLK),
      .RST_n     (RST_n),
      .byte_in   (rx_data_q),
      .strobe    (rx_valid_q),
      .enable    (~SEND_END_cmd),
      .clear_req (clear_req),
      .found     (receiver_OK_ser)
   );

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_ok.sv
// tb/tb_uart_rx_ok.sv - randomized self-checking bench for uart_rx_ok
module tb_uart_rx_ok;

   localparam int CLK_HZ = 2_304_000;
   localparam int BAUD   = 115200;
   localparam int DIV    = 20;
   localparam int H      = 10;
   localparam int LAT    = 9 * DIV + H + 3;

   logic       iCLK = 1'b0;
   logic       RST_n = 1'b0;
   logic       rx = 1'b1;
   logic       receive_ok_en = 1'b0;
   logic       SEND_END_cmd = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       receiver_OK_ser;

   int         n_checks = 0;
   int         n_pass = 0;
   int         cycle_cnt = 0;
   int         n_valid = 0;
   int         n_ferr = 0;
   int         valid_cyc = 0;
   int         flag_rise_cyc = 0;
   int         start_cyc = 0;
   logic [7:0] last_byte = 8'h00;
   logic       flag_prev = 1'b0;

   logic [31:0] win = 32'h0;
   logic        model_flag = 1'b0;

   uart_rx_ok #(.CLK(CLK_HZ), .BAUD_RATE(BAUD)) dut (
      .iCLK            (iCLK),
      .RST_n           (RST_n),
      .rx              (rx),
      .receive_ok_en   (receive_ok_en),
      .SEND_END_cmd    (SEND_END_cmd),
      .rx_data         (rx_data),
      .rx_valid        (rx_valid),
      .frame_err       (frame_err),
      .receiver_OK_ser (receiver_OK_ser)
   );

   always #5 iCLK = ~iCLK;

   always @(posedge iCLK) cycle_cnt <= cycle_cnt + 1;

   always @(negedge iCLK) begin
      if (rx_valid) begin
         n_valid   = n_valid + 1;
         valid_cyc = cycle_cnt;
         last_byte = rx_data;
      end
      if (frame_err) n_ferr = n_ferr + 1;
      if (receiver_OK_ser && !flag_prev) flag_rise_cyc = cycle_cnt;
      flag_prev = receiver_OK_ser;
   end

   task automatic hold(input int n);
      repeat (n) @(posedge iCLK);
      #1;
   endtask

   // Reference: the flag is raised when the last four accepted bytes spell OK\r\n.
   task automatic model_byte(input logic [7:0] b);
      if (SEND_END_cmd) begin
         win = 32'h0;
      end else begin
         win = {win[23:0], b};
         if (win == 32'h4F4B0D0A) model_flag = 1'b1;
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int low_tail);
      rx = 1'b0;
      start_cyc = cycle_cnt;
      hold(DIV);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         hold(DIV);
      end
      rx = stop_bit;
      hold(DIV + low_tail);
      rx = 1'b1;
      hold(3);
   endtask

   task automatic xfer_byte(input logic [7:0] b);
      int nv0;
      nv0 = n_valid;
      send_frame(b, 1'b1, 0);
      model_byte(b);
      n_checks++;
      if (n_valid !== nv0 + 1 || last_byte !== b)
         $display("FAIL rx_byte: got %0d pulses data %02h, expected 1 pulse data %02h", n_valid - nv0, last_byte, b);
      else n_pass++;
      n_checks++;
      if (receiver_OK_ser !== model_flag)
         $display("FAIL ok_flag after %02h: got %b, expected %b", b, receiver_OK_ser, model_flag);
      else n_pass++;
   endtask

   task automatic pulse_ok_en();
      receive_ok_en = 1'b1;
      hold(5);
      n_checks++;
      if (receiver_OK_ser !== model_flag)
         $display("FAIL ok_flag_hold: got %b, expected %b", receiver_OK_ser, model_flag);
      else n_pass++;
      receive_ok_en = 1'b0;
      hold(1);
      model_flag = 1'b0;
      n_checks++;
      if (receiver_OK_ser !== 1'b0)
         $display("FAIL ok_flag_clear: got %b, expected 0", receiver_OK_ser);
      else n_pass++;
   endtask

   task automatic test_reset();
      n_checks++;
      if ({rx_data, rx_valid, frame_err, receiver_OK_ser} !== 11'h0)
         $display("FAIL reset_outputs: got %03h, expected 000", {rx_data, rx_valid, frame_err, receiver_OK_ser});
      else n_pass++;
   endtask

   task automatic test_latency();
      int fe0;
      fe0 = n_ferr;
      xfer_byte(8'h55);
      n_checks++;
      if (valid_cyc - start_cyc < LAT - 1 || valid_cyc - start_cyc > LAT + 1)
         $display("FAIL latency: got %0d cycles, expected %0d +/-1", valid_cyc - start_cyc, LAT);
      else n_pass++;
      n_checks++;
      if (n_ferr !== fe0) $display("FAIL latency_ferr: got %0d, expected %0d", n_ferr, fe0);
      else n_pass++;
   endtask

   task automatic test_ok();
      xfer_byte(8'h4F); xfer_byte(8'h4B); xfer_byte(8'h0D); xfer_byte(8'h0A);
      n_checks++;
      if (flag_rise_cyc !== valid_cyc + 1)
         $display("FAIL ok_rise: got cycle %0d, expected %0d", flag_rise_cyc, valid_cyc + 1);
      else n_pass++;
      pulse_ok_en();
   endtask

   task automatic test_variants();
      xfer_byte(8'h4F); xfer_byte(8'h4F); xfer_byte(8'h4B); xfer_byte(8'h0D); xfer_byte(8'h0A);
      pulse_ok_en();
      xfer_byte(8'h4F); xfer_byte(8'h4B); xfer_byte(8'h0D); xfer_byte(8'h58); xfer_byte(8'h0A);
      // Index must have returned to 0: "K\r\n" alone may not complete a match.
      xfer_byte(8'h4B); xfer_byte(8'h0D); xfer_byte(8'h0A);
   endtask

   task automatic test_glitch();
      int nv0, fe0;
      nv0 = n_valid;
      fe0 = n_ferr;
      rx = 1'b0;
      hold(H - 3);
      rx = 1'b1;
      hold(3 * DIV);
      n_checks++;
      if (n_valid !== nv0 || n_ferr !== fe0)
         $display("FAIL glitch: got valid+%0d ferr+%0d, expected 0 and 0", n_valid - nv0, n_ferr - fe0);
      else n_pass++;
      xfer_byte(8'hA5);
   endtask

   task automatic test_frame_err();
      int nv0, fe0;
      logic [7:0] rd;
      xfer_byte(8'h4F); xfer_byte(8'h4B); xfer_byte(8'h0D);
      nv0 = n_valid;
      fe0 = n_ferr;
      rd = last_byte;
      send_frame(8'hA5, 1'b0, 3 * DIV);
      n_checks++;
      if (n_ferr !== fe0 + 1) $display("FAIL ferr_pulse: got %0d, expected %0d", n_ferr - fe0, 1);
      else n_pass++;
      n_checks++;
      if (n_valid !== nv0) $display("FAIL ferr_no_valid: got %0d, expected 0", n_valid - nv0);
      else n_pass++;
      n_checks++;
      if (rx_data !== rd) $display("FAIL ferr_data: got %02h, expected %02h", rx_data, rd);
      else n_pass++;
      xfer_byte(8'h0A);
      pulse_ok_en();
   endtask

   task automatic test_reset_mid();
      logic [7:0] b;
      int nv0;
      xfer_byte(8'h4F); xfer_byte(8'h4B); xfer_byte(8'h0D); xfer_byte(8'h0A);
      b = 8'h3C;
      rx = 1'b0;
      hold(DIV);
      for (int i = 0; i < 4; i++) begin
         rx = b[i];
         hold(DIV);
      end
      rx = b[4];
      hold(H);
      RST_n = 1'b0;
      hold(1);
      n_checks++;
      if ({rx_data, rx_valid, frame_err, receiver_OK_ser} !== 11'h0)
         $display("FAIL reset_mid_outputs: got %03h, expected 000", {rx_data, rx_valid, frame_err, receiver_OK_ser});
      else n_pass++;
      rx = 1'b1;
      hold(6 * DIV);
      nv0 = n_valid;
      RST_n = 1'b1;
      win = 32'h0;
      model_flag = 1'b0;
      hold(3);
      n_checks++;
      if (n_valid !== nv0) $display("FAIL reset_discard: got %0d pulses, expected 0", n_valid - nv0);
      else n_pass++;
      xfer_byte(8'hC3);
   endtask

   task automatic test_send_end();
      int nv0;
      nv0 = n_valid;
      SEND_END_cmd = 1'b1;
      xfer_byte(8'h4F); xfer_byte(8'h4B); xfer_byte(8'h0D); xfer_byte(8'h0A);
      n_checks++;
      if (n_valid !== nv0 + 4) $display("FAIL send_end_valids: got %0d, expected 4", n_valid - nv0);
      else n_pass++;
      SEND_END_cmd = 1'b0;
   endtask

   task automatic test_random();
      logic [7:0] seq [4];
      seq[0] = 8'h4F; seq[1] = 8'h4B; seq[2] = 8'h0D; seq[3] = 8'h0A;
      for (int n = 0; n < 20; n++) begin
         SEND_END_cmd = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 2) == 0) begin
            for (int k = 0; k < 4; k++) xfer_byte(seq[k]);
         end else begin
            xfer_byte(8'($urandom_range(0, 255)));
         end
         if ($urandom_range(0, 3) == 0) pulse_ok_en();
      end
      SEND_END_cmd = 1'b0;
   endtask

   initial begin
      hold(5);
      test_reset();
      RST_n = 1'b1;
      hold(3);
      test_latency();
      test_ok();
      test_variants();
      test_glitch();
      test_frame_err();
      test_reset_mid();
      test_send_end();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
